// File: rtl/tinyqv_shift_pkg.sv
// tinyqv_shift_pkg: op codes, FSM state type and op validity helper for the
// slice-serial shift/rotate unit.
// Optional feature macro: TINYQV_SHIFT_ROTATE_EN (enables ROL/ROR).
package tinyqv_shift_pkg;

    localparam logic [3:0] OP_SLL = 4'b0001;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SRA = 4'b1101;
    localparam logic [3:0] OP_ROL = 4'b0011;
    localparam logic [3:0] OP_ROR = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // True when the op code is implemented in this build; anything else
    // produces an all-zero result.
    function automatic logic op_valid(input logic [3:0] op);
        case (op)
            OP_SLL, OP_SRL, OP_SRA: op_valid = 1'b1;
`ifdef TINYQV_SHIFT_ROTATE_EN
            OP_ROL, OP_ROR:         op_valid = 1'b1;
`endif
            default:                op_valid = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tinyqv_shift_slice.sv
// tinyqv_shift_slice: combinational generator for one SLICE-bit piece of a
// shift/rotate result, selected by slice index.
// Optional feature macro: TINYQV_SHIFT_ROTATE_EN (adds the rotate wrap paths).
module tinyqv_shift_slice
    import tinyqv_shift_pkg::*;
#(
    parameter int  XLEN  = 32,
    parameter int  SLICE = 4,
    localparam int BW    = $clog2(XLEN),
    localparam int N     = XLEN / SLICE,
    localparam int IW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic [3:0]       op,
    input  logic [XLEN-1:0]  a,
    input  logic [BW-1:0]    b,
    input  logic [IW-1:0]    idx,
    output logic [SLICE-1:0] slice
);

    // Per result bit: up = i+b (carry means past the MSB), dn = i-b (borrow
    // means below bit 0). Rotates simply drop the carry/borrow, which wraps
    // modulo XLEN because XLEN is a power of two.
    always_comb begin
        logic [BW-1:0] pos;
        logic [BW:0]   up;
        logic [BW:0]   dn;
        slice = '0;
        pos   = '0;
        up    = '0;
        dn    = '0;
        for (int j = 0; j < SLICE; j++) begin
            pos = BW'(int'(idx) * SLICE + j);
            up  = {1'b0, pos} + {1'b0, b};
            dn  = {1'b0, pos} - {1'b0, b};
            if (op_valid(op)) begin
                case (op)
                    OP_SLL:  slice[j] = dn[BW] ? 1'b0 : a[dn[BW-1:0]];
                    OP_SRL:  slice[j] = up[BW] ? 1'b0 : a[up[BW-1:0]];
                    OP_SRA:  slice[j] = up[BW] ? a[XLEN-1] : a[up[BW-1:0]];
`ifdef TINYQV_SHIFT_ROTATE_EN
                    OP_ROL:  slice[j] = a[dn[BW-1:0]];
                    OP_ROR:  slice[j] = a[up[BW-1:0]];
`endif
                    default: slice[j] = 1'b0;
                endcase
            end
        end
    end

endmodule

// File: rtl/tinyqv_shift_unit.sv
// tinyqv_shift_unit: slice-serial shift/rotate execution unit. Produces
// SLICE result bits per cycle over N = XLEN/SLICE RUN cycles, accumulating
// them into a registered result, then pulses done for one cycle.
// Optional feature macro: TINYQV_SHIFT_ROTATE_EN (ROL/ROR support).
//
// Handshake: start is a request accepted on any clock edge where the unit is
// in IDLE or DONE; op/a/b are captured on that edge and may change afterwards.
// start while busy is ignored. done is a one-cycle pulse in the DONE state,
// during which a new start is accepted (back-to-back, no idle gap). result
// holds its value until the next accepted start clears it.
module tinyqv_shift_unit
    import tinyqv_shift_pkg::*;
#(
    parameter int  XLEN  = 32,
    parameter int  SLICE = 4,
    localparam int BW    = $clog2(XLEN),
    localparam int N     = XLEN / SLICE,
    localparam int IW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [XLEN-1:0]  a,
    input  logic [BW-1:0]    b,
    output logic             busy,
    output logic             slice_valid,
    output logic [IW-1:0]    slice_idx,
    output logic [SLICE-1:0] slice_out,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output state_e           state_dbg
);

    state_e           state_q;
    state_e           state_d;
    logic             accept;
    logic             last;
    logic [IW-1:0]    count_q;
    logic [3:0]       op_q;
    logic [XLEN-1:0]  a_q;
    logic [BW-1:0]    b_q;
    logic [XLEN-1:0]  result_q;
    logic [SLICE-1:0] slice_w;

    assign last      = (count_q == IW'(N - 1));
    assign result    = result_q;
    assign state_dbg = state_q;

    tinyqv_shift_slice #(
        .XLEN  (XLEN),
        .SLICE (SLICE)
    ) u_slice (
        .op    (op_q),
        .a     (a_q),
        .b     (b_q),
        .idx   (count_q),
        .slice (slice_w)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and handshake/slice outputs; slice outputs are forced to zero
    // outside RUN so they read as reset values when idle.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        slice_valid = 1'b0;
        slice_idx   = '0;
        slice_out   = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy        = 1'b1;
                slice_valid = 1'b1;
                slice_idx   = count_q;
                slice_out   = slice_w;
                if (last) state_d = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand latches, slice counter and result accumulation.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q  <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else if (accept) begin
            count_q  <= '0;
            op_q     <= op;
            a_q      <= a;
            b_q      <= b;
            result_q <= '0;
        end else if (state_q == ST_RUN) begin
            count_q <= last ? '0 : count_q + 1'b1;
            for (int k = 0; k < N; k++) begin
                if (count_q == IW'(k)) result_q[k*SLICE +: SLICE] <= slice_w;
            end
        end
    end

endmodule

// File: tb/tb_tinyqv_shift_unit.sv
// tb_tinyqv_shift_unit: scoreboard bench for tinyqv_shift_unit (32/4 main
// instance, 32/8 secondary instance). Expectations come from a word-level
// shift model; rotate expectations follow TINYQV_SHIFT_ROTATE_EN.
module tb_tinyqv_shift_unit;
    import tinyqv_shift_pkg::*;

    localparam int XLEN  = 32;
    localparam int SLICE = 4;
    localparam int N     = XLEN / SLICE;

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT (32/4) ----------------
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [4:0]  b;
    logic        busy, slice_valid, done;
    logic [2:0]  slice_idx;
    logic [3:0]  slice_out;
    logic [31:0] result;
    state_e      state_dbg;

    tinyqv_shift_unit #(.XLEN(32), .SLICE(4)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .slice_valid (slice_valid),
        .slice_idx   (slice_idx),
        .slice_out   (slice_out),
        .done        (done),
        .result      (result),
        .state_dbg   (state_dbg)
    );

    // ---------------- DUT (32/8) ----------------
    logic        start8;
    logic [3:0]  op8;
    logic [31:0] a8;
    logic [4:0]  b8;
    logic        busy8, slice_valid8, done8;
    logic [1:0]  slice_idx8;
    logic [7:0]  slice_out8;
    logic [31:0] result8;
    state_e      state_dbg8;

    tinyqv_shift_unit #(.XLEN(32), .SLICE(8)) dut8 (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start8),
        .op          (op8),
        .a           (a8),
        .b           (b8),
        .busy        (busy8),
        .slice_valid (slice_valid8),
        .slice_idx   (slice_idx8),
        .slice_out   (slice_out8),
        .done        (done8),
        .result      (result8),
        .state_dbg   (state_dbg8)
    );

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [6:0]  slice_q[$];   // {idx, slice value}
    logic [31:0] last_exp = '0;
    int          cyc;
    int          busy_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_fn(input logic [3:0] o, input logic [31:0] x,
                                           input logic [4:0] s);
        case (o)
            OP_SLL:  return x << s;
            OP_SRL:  return x >> s;
            OP_SRA:  return 32'($signed(x) >>> s);
`ifdef TINYQV_SHIFT_ROTATE_EN
            OP_ROL:  return (s == 5'd0) ? x : ((x << s) | (x >> (6'd32 - {1'b0, s})));
            OP_ROR:  return (s == 5'd0) ? x : ((x >> s) | (x << (6'd32 - {1'b0, s})));
`endif
            default: return '0;
        endcase
    endfunction

    // Slice, busy and completion monitor for the 32/4 instance.
    always @(negedge clk) begin
        logic [6:0]  sv;
        logic [31:0] e;
        if (busy) busy_cnt++;
        if (slice_valid) begin
            check("slice_pending", slice_q.size() > 0, 1'b1);
            if (slice_q.size() > 0) begin
                sv = slice_q.pop_front();
                check("slice_idx", slice_idx, sv[6:4]);
                check("slice_out", slice_out, sv[3:0]);
            end
        end
        if (done) begin
            check("result_pending", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("result", result, e);
                last_exp = e;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; leaves start low one negedge later.
    task automatic start_op(input logic [3:0] o, input logic [31:0] x, input logic [4:0] s);
        logic [31:0] e;
        op    = o;
        a     = x;
        b     = s;
        start = 1'b1;
        e     = exp_fn(o, x, s);
        exp_q.push_back(e);
        for (int k = 0; k < N; k++) slice_q.push_back({3'(k), 4'(e >> (4 * k))});
        cyc      = 0;
        busy_cnt = 0;
        @(negedge clk);
        cyc   = 1;
        start = 1'b0;
        a     = $urandom;
        b     = 5'($urandom_range(0, 31));
        op    = 4'($urandom_range(0, 15));
    endtask

    // Returns at the negedge inside the DONE cycle (or after the bound).
    task automatic wait_done(input string tag);
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, N + 1);
        check({tag, "_busy_cycles"}, busy_cnt, N);
    endtask

    task automatic go_idle_and_hold(input string tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 1'b0);
        check({tag, "_hold"}, result, last_exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0]  codes[8];
        logic [31:0] asm8;
        int          bc8;
        int          c8;
        codes = '{OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR, 4'b0000, 4'b1111, 4'b1001};
        start  = 1'b0; op  = '0; a  = '0; b  = '0;
        start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_slice_valid", slice_valid, 1'b0);
        check("rst_slice_idx", slice_idx, 3'd0);
        check("rst_slice_out", slice_out, 4'd0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, 32'd0);
        check("rst_state", state_dbg, ST_IDLE);
        rstn = 1'b1;
        @(negedge clk);

        // SLL 1 << 31.
        start_op(OP_SLL, 32'h0000_0001, 5'd31);
        wait_done("sll31");
        check("tp_sll31", result, 32'h8000_0000);
        go_idle_and_hold("sll31");

        // SRA / SRL on the same operand.
        start_op(OP_SRA, 32'h8000_00F0, 5'd4);
        wait_done("sra4");
        check("tp_sra4", result, 32'hF800_000F);
        go_idle_and_hold("sra4");
        start_op(OP_SRL, 32'h8000_00F0, 5'd4);
        wait_done("srl4");
        check("tp_srl4", result, 32'h0800_000F);
        go_idle_and_hold("srl4");

        // Rotates (zero when the feature is not built).
        start_op(OP_ROR, 32'h1234_5678, 5'd8);
        wait_done("ror8");
`ifdef TINYQV_SHIFT_ROTATE_EN
        check("tp_ror8", result, 32'h7812_3456);
`else
        check("tp_ror8", result, 32'h0000_0000);
`endif
        go_idle_and_hold("ror8");
        start_op(OP_ROL, 32'h1234_5678, 5'd4);
        wait_done("rol4");
`ifdef TINYQV_SHIFT_ROTATE_EN
        check("tp_rol4", result, 32'h2345_6781);
`else
        check("tp_rol4", result, 32'h0000_0000);
`endif
        go_idle_and_hold("rol4");

        // Back-to-back: start in the DONE cycle.
        start_op(OP_SRL, 32'hCAFE_F00D, 5'd16);
        wait_done("b2b_first");
        start_op(OP_SLL, 32'h0000_ABCD, 5'd8);
        wait_done("b2b_second");
        check("tp_b2b_second", result, 32'h00AB_CD00);
        go_idle_and_hold("b2b");

        // start with new operands during RUN is ignored.
        start_op(OP_SLL, 32'h0000_00FF, 5'd4);
        @(negedge clk); cyc++;
        start = 1'b1; a = 32'hFFFF_FFFF; op = OP_SRA; b = 5'd1;
        @(negedge clk); cyc++;
        start = 1'b0;
        wait_done("ignore");
        check("tp_ignore", result, 32'h0000_0FF0);
        go_idle_and_hold("ignore");

        // Reset during slice 3.
        start_op(OP_SRA, 32'hF0F0_F0F0, 5'd3);
        while (slice_idx !== 3'd3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_rst_reached_slice3", slice_idx, 3'd3);
        #2 rstn = 1'b0;
        #1;
        exp_q.delete();
        slice_q.delete();
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_slice_valid", slice_valid, 1'b0);
        check("mid_rst_slice_idx", slice_idx, 3'd0);
        check("mid_rst_slice_out", slice_out, 4'd0);
        check("mid_rst_result", result, 32'd0);
        check("mid_rst_state", state_dbg, ST_IDLE);
        repeat (3) begin
            @(negedge clk);
            check("mid_rst_no_done", done, 1'b0);
        end
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_no_done", done, 1'b0);
        start_op(OP_SLL, 32'hFFFF_FFFF, 5'd0);
        wait_done("post_rst");
        check("tp_post_rst", result, 32'hFFFF_FFFF);
        go_idle_and_hold("post_rst");

        // Randomised ops, randomly back-to-back.
        for (int i = 0; i < 24; i++) begin
            start_op(codes[$urandom_range(0, 7)], $urandom, 5'($urandom_range(0, 31)));
            wait_done("rand");
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end
        @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("slice_q_drained", slice_q.size(), 0);

        // 32/8 instance: SRL 0xDEADBEEF by 12.
        asm8 = '0;
        bc8  = 0;
        c8   = 0;
        op8 = OP_SRL; a8 = 32'hDEAD_BEEF; b8 = 5'd12; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = $urandom;
        c8 = 1;
        while (done8 !== 1'b1 && c8 < 30) begin
            if (busy8) bc8++;
            if (slice_valid8) asm8[slice_idx8*8 +: 8] = slice_out8;
            @(negedge clk);
            c8++;
        end
        check("s8_latency", c8, 5);
        check("s8_busy_cycles", bc8, 4);
        check("s8_result", result8, 32'h000D_EADB);
        check("s8_slices", asm8, 32'h000D_EADB);
        @(negedge clk);
        check("s8_done_pulse", done8, 1'b0);
        check("s8_hold", result8, 32'h000D_EADB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tinyqv_shift_unit.md
# tinyqv_shift_unit

Parametrised slice-serial shift/rotate execution unit for the tinyQV datapath. It generalises the fixed 4-bit-per-cycle, 32-bit shifter to a configurable word width and slice width, and adds a start/done handshake, internal slice sequencing, a registered result and optional rotate ops. It sits beside the ALU and feeds the writeback stage.

## Interface
- `XLEN`, 32: word width; power of two, 8 to 64.
- `SLICE`, 4: result bits produced per cycle; power of two that divides `XLEN`, 1 to `XLEN`.
- `clk`  in  1  clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; accepted only in IDLE or DONE.
- `op`  in  4  operation code; sampled with `start`.
- `a`  in  XLEN  operand; sampled with `start`.
- `b`  in  $clog2(XLEN)  shift amount; sampled with `start`.
- `busy`  out  1  high in RUN.
- `slice_valid`  out  1  `slice_out` is valid this cycle.
- `slice_idx`  out  $clog2(XLEN/SLICE)  index of `slice_out`; 0 is least significant.
- `slice_out`  out  SLICE  result bits `[slice_idx*SLICE +: SLICE]`.
- `done`  out  1  one-cycle pulse; `result` is complete.
- `result`  out  XLEN  full result; held until the next accepted `start`.

## Operation
- Op codes: SLL 4'b0001, SRL 4'b0101, SRA 4'b1101, ROL 4'b0011, ROR 4'b0111.
- Any other code yields all-zero slices and completes normally.
- Definitions per result bit i, with b taken modulo XLEN:
  - SLL: a[i-b] if i>=b, else 0.
  - SRL: a[i+b] if i+b<XLEN, else 0.
  - SRA: as SRL, but fill with a[XLEN-1].
  - ROL: a[(i-b) mod XLEN].
  - ROR: a[(i+b) mod XLEN].
- States:
  - IDLE: `start` → RUN.
  - RUN: count from 0 to N-1, where N = XLEN/SLICE. At count N-1 → DONE.
  - DONE: lasts one cycle. `start` → RUN, otherwise → IDLE.
- On an accepted `start`: latch `op`, `a` and `b`, clear `result` to 0 and set count to 0.
- While in RUN, each cycle:
  - Compute slice `count` from the latched operands.
  - Write it into `result[count*SLICE +: SLICE]`.
  - Present it on `slice_out` with `slice_idx`=count and `slice_valid`=1.
- `start` during RUN is ignored. The operands latched at acceptance stay in use and the inputs are not re-sampled.
- `a`, `b` and `op` may change freely after acceptance.

## Timing
- `start` sampled at edge E0 → slice k is visible in the cycle after edge E(k).
- `done` is high in the cycle after E(N-1)+1, i.e. start-to-done latency is N+1 edges. Concretely, `done` is asserted in the DONE state.
- `busy`=1 exactly N cycles per operation.
- Back-to-back: `start` in the DONE cycle is accepted. The next RUN begins on the following edge, giving throughput of one operation per N+1 cycles.
- Reset values: state IDLE, count 0, `busy` 0, `slice_valid` 0, `slice_idx` 0, `slice_out` 0, `done` 0, `result` 0.
- Reset mid-RUN: aborts immediately, no `done`, `result` returns to 0.
- `SLICE`=`XLEN`: N=1; a single RUN cycle, and `slice_idx` is width 1, tied to 0.

## Configuration
- `TINYQV_SHIFT_ROTATE_EN` defined: ROL and ROR are implemented as above.
- Not defined:
  - ROL and ROR are unrecognised codes and produce zero.
  - No rotate wrap logic is synthesised.

## Structure
- Package `tinyqv_shift_pkg` holds:
  - the op code localparams;
  - an enum for IDLE/RUN/DONE;
  - a function returning whether an op is valid under the current configuration.
- Sub-module `tinyqv_shift_slice` is purely combinational:
  - parameters `XLEN` and `SLICE`;
  - inputs op, a, b and slice index;
  - output one slice.
- The top level holds the FSM, counter, operand latches and result register.

## Test plan
All cases use XLEN=32, SLICE=4 unless noted.
- SLL, a=0x00000001, b=31 → `result`=0x80000000, with `done` exactly 9 edges after the `start` edge and `slice_out` 0 for idx 0–6 and 0x8 for idx 7.
- SRA, a=0x800000F0, b=4 → `result`=0xF800000F, first slice 0xF; SRL with the same inputs → 0x0800000F.
- ROR, a=0x12345678, b=8, macro defined → 0x78123456; ROL with b=4 → 0x23456781. Macro undefined, op 4'b0111 → 0x00000000 and `done` still pulses.
- `start` in the DONE cycle → a second operation runs with no idle gap. `start` with new `a` during RUN → ignored, and the first result is unchanged.
- `rstn` low during slice 3 → no `done`, all outputs at reset values; a subsequent SLL a=0xFFFFFFFF, b=0 → 0xFFFFFFFF.
- XLEN=32, SLICE=8, SRL a=0xDEADBEEF, b=12 → 0x000DEADB, `busy` high for 4 cycles.
